// File: rtl/suma_comb_if.sv
// Purpose : streaming handshake bundle for the suma_comb comb stage (running sum in, window sum out).
// Latency : n/a (signal bundle only).
// Backpr. : valid/ready on both sides; in_ready is driven by the comb stage.
// Ports   : in_valid/in_ready/acc_in (upstream), out_valid/out_ready/diff_out[/mean_out] (downstream).
// Option  : SUMA_COMB_MEAN_EN adds the mean_out signal.
interface suma_comb_if #(
   parameter int W_IN = 16,
   parameter int W_D  = 8,
   parameter int W_M  = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [W_IN-1:0] acc_in;
   logic            out_valid;
   logic            out_ready;
   logic [W_D-1:0]  diff_out;
`ifdef SUMA_COMB_MEAN_EN
   logic [W_M-1:0]  mean_out;
`endif

   // Producer of running sums / consumer of window sums.
   modport master (
      output in_valid, acc_in, out_ready,
      input  in_ready, out_valid, diff_out
`ifdef SUMA_COMB_MEAN_EN
      , input mean_out
`endif
   );

   // The comb stage itself.
   modport slave (
      input  in_valid, acc_in, out_ready,
      output in_ready, out_valid, diff_out
`ifdef SUMA_COMB_MEAN_EN
      , output mean_out
`endif
   );
endinterface

// File: rtl/suma_comb.sv
// Purpose : comb stage of a CIC-style averager: window sum of the last OSF running-sum words.
// Latency : 1 cycle from an accepted input (once the window is full) to out_valid.
// Backpr. : in_ready = !out_valid || out_ready (forced high in reset); output held until taken.
// Ports   : clk, rst (sync, active-high), s (suma_comb_if.slave: acc_in in, diff_out[/mean_out] out).
// Option  : define SUMA_COMB_MEAN_EN to add the registered mean_out = diff_out >> log2(OSF).
module suma_comb #(
   parameter int SAMPLES = 128,
   parameter int OSF     = 8,
   parameter int SIZE    = 12
) (
   input  logic        clk,
   input  logic        rst,
   suma_comb_if.slave  s
);
   localparam int W_IN = $clog2(SAMPLES*OSF) + SIZE + 2;
   localparam int W_D  = $clog2(OSF) + SIZE + 1;
   localparam int PW   = $clog2(OSF);

   typedef enum logic {FILL, RUN} state_t;

   state_t          state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   fill_q;
   logic [W_IN-1:0] line_q [OSF];
   logic            out_valid_q;
   logic [W_D-1:0]  diff_q;
`ifdef SUMA_COMB_MEAN_EN
   logic [SIZE:0]   mean_q;
`endif

   logic            in_xfer;
   logic            produce;
   logic [PW-1:0]   ptr_d;
   logic [W_D-1:0]  diff_d;

   // Reset term keeps in_ready high while rst is asserted; any transfer it
   // admits is discarded because the reset branch below dominates.
   assign s.in_ready = rst || !out_valid_q || s.out_ready;
   assign in_xfer    = s.in_valid && s.in_ready;

   // OSF is a power of two, so the pointer wraps OSF-1 -> 0 on its own.
   assign ptr_d = ptr_q + 1'b1;

   // Difference is taken modulo 2^W_IN, so a wrapped running sum still
   // yields the true window sum; only the low W_D bits are meaningful.
   assign diff_d = W_D'(s.acc_in - line_q[ptr_q]);

   // The OSF-th accepted word completes the first window.
   assign produce = in_xfer && ((state_q == RUN) || (fill_q == PW'(OSF-1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         ptr_q       <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
`ifdef SUMA_COMB_MEAN_EN
         mean_q      <= '0;
`endif
         for (int i = 0; i < OSF; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         if (in_xfer) begin
            line_q[ptr_q] <= s.acc_in;
            ptr_q         <= ptr_d;
         end

         if (state_q == FILL && in_xfer) begin
            if (fill_q == PW'(OSF-1)) begin
               state_q <= RUN;
            end else begin
               fill_q <= fill_q + 1'b1;
            end
         end

         // A new result reloads the register even when the old one leaves
         // this cycle; otherwise a taken output clears valid.
         if (produce) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
`ifdef SUMA_COMB_MEAN_EN
            mean_q      <= diff_d[W_D-1:PW];
`endif
         end else if (s.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign s.out_valid = out_valid_q;
   assign s.diff_out  = diff_q;
`ifdef SUMA_COMB_MEAN_EN
   assign s.mean_out  = mean_q;
`endif

endmodule

// File: tb/tb_suma_comb.sv
// Purpose : self-checking bench for suma_comb (SIZE=4, OSF=8, SAMPLES=128).
// Latency : n/a.
// Backpr. : drives out_ready directly to exercise stalls.
module tb_suma_comb;
   localparam int SAMPLES = 128;
   localparam int OSF     = 8;
   localparam int SIZE    = 4;
   localparam int W_IN    = $clog2(SAMPLES*OSF) + SIZE + 2;
   localparam int W_D     = $clog2(OSF) + SIZE + 1;
   localparam int LOG2    = $clog2(OSF);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   suma_comb_if #(.W_IN(W_IN), .W_D(W_D), .W_M(SIZE+1)) bus ();

   suma_comb #(.SAMPLES(SAMPLES), .OSF(OSF), .SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard: expected window sums and the history of accepted inputs.
   logic [W_D-1:0]  exp_q [$];
   logic [W_IN-1:0] hist  [$];
   int              m_cnt;
   logic            m_ov;
   logic [W_IN-1:0] a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      hist.delete();
      m_cnt = 0;
      m_ov  = 1'b0;
   endtask

   // One clock of stimulus: drive at negedge, check, then update the model.
   task automatic step(input logic v, input logic [W_IN-1:0] av, input logic ordy);
      logic            acc;
      logic [W_IN-1:0] old;
      @(negedge clk);
      bus.in_valid  = v;
      bus.acc_in    = av;
      bus.out_ready = ordy;
      #1;
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (!m_ov || ordy)});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
      if (m_ov && exp_q.size() > 0) begin
         chk("diff_out", 32'(bus.diff_out), 32'(exp_q[0]));
`ifdef SUMA_COMB_MEAN_EN
         chk("mean_out", 32'(bus.mean_out), 32'(exp_q[0] >> LOG2));
`endif
         if (ordy) void'(exp_q.pop_front());
      end
      acc = v && (!m_ov || ordy);
      if (acc) begin
         old = '0;
         if (hist.size() >= OSF) old = hist.pop_front();
         hist.push_back(av);
         m_cnt++;
         if (m_cnt >= OSF) begin
            exp_q.push_back(W_D'(av - old));
            m_ov = 1'b1;
         end else if (ordy) begin
            m_ov = 1'b0;
         end
      end else if (ordy) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.acc_in    = W_IN'(123);
      bus.out_ready = 1'b0;
      #1;
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_diff_out", 32'(bus.diff_out), 32'd0);
`ifdef SUMA_COMB_MEAN_EN
      chk("rst_mean_out", 32'(bus.mean_out), 32'd0);
`endif
      chk("rst_in_ready2", {31'b0, bus.in_ready}, 32'd1);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.acc_in    = '0;
      bus.out_ready = 1'b1;
      model_reset();
      do_reset();

      // Fill: 3,6,..,24; only the 8th input yields an output (24, mean 3).
      for (int i = 1; i <= OSF; i++) step(1'b1, W_IN'(3*i), 1'b1);
      step(1'b0, '0, 1'b0);
      chk("s1_diff24", 32'(bus.diff_out), 32'd24);
`ifdef SUMA_COMB_MEAN_EN
      chk("s1_mean3", 32'(bus.mean_out), 32'd3);
`endif

      // Step of 5: outputs 26..40, then 40 steady.
      a = W_IN'(24);
      for (int i = 0; i < 10; i++) begin
         a = a + W_IN'(5);
         step(1'b1, a, 1'b1);
      end
      step(1'b0, '0, 1'b0);
      chk("s2_steady40", 32'(bus.diff_out), 32'd40);

      // Running sum wraps through zero; window sum of step 4 is 32.
      a = W_IN'(17'h1FFF0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, a, 1'b1);
         a = a + W_IN'(4);
      end
      step(1'b0, '0, 1'b0);
      chk("s3_wrap32", 32'(bus.diff_out), 32'd32);

      // Downstream stall for 5 cycles with in_valid held high, then release.
      repeat (5) step(1'b1, a, 1'b0);
      step(1'b1, a, 1'b1);
      for (int i = 0; i < 5; i++) begin
         a = a + W_IN'(4);
         step(1'b1, a, 1'b1);
      end

      // Reset while an output is pending, then refill from scratch.
      step(1'b0, '0, 1'b0);
      do_reset();
      for (int i = 1; i <= OSF; i++) step(1'b1, W_IN'(10*i), 1'b1);
      step(1'b0, '0, 1'b0);
      chk("s5_diff80", 32'(bus.diff_out), 32'd80);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
